// File: rtl/axis_data_width_upsizer.sv
// Narrow-to-wide AXI Stream converter: packs RATIO input beats per output word, never across packets.
// Optional AXIS_UPSIZER_KEEP_CHECK_EN adds a registered keep_error pulse for malformed TKEEP.
module axis_data_width_upsizer #(
  parameter int IN_TDATA_WIDTH  = 64,
  parameter int OUT_TDATA_WIDTH = IN_TDATA_WIDTH * 4,
  parameter int TUSER_WIDTH     = 128
) (
  input  logic                         axis_aclk,
  input  logic                         axis_reset,
  input  logic [IN_TDATA_WIDTH-1:0]    axis_original_tdata,
  input  logic [IN_TDATA_WIDTH/8-1:0]  axis_original_tkeep,
  input  logic [TUSER_WIDTH-1:0]       axis_original_tuser,
  input  logic                         axis_original_tvalid,
  output logic                         axis_original_tready,
  input  logic                         axis_original_tlast,
  output logic [OUT_TDATA_WIDTH-1:0]   axis_resize_tdata,
  output logic [OUT_TDATA_WIDTH/8-1:0] axis_resize_tkeep,
  output logic [TUSER_WIDTH-1:0]       axis_resize_tuser,
  output logic                         axis_resize_tvalid,
  input  logic                         axis_resize_tready,
  output logic                         axis_resize_tlast
`ifdef AXIS_UPSIZER_KEEP_CHECK_EN
  ,
  output logic                         keep_error
`endif
);

  localparam int RATIO    = OUT_TDATA_WIDTH / IN_TDATA_WIDTH;
  localparam int IN_KEEP  = IN_TDATA_WIDTH / 8;
  localparam int OUT_KEEP = OUT_TDATA_WIDTH / 8;
  localparam int CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [CNT_W-1:0]           cnt_reg;
  logic [OUT_TDATA_WIDTH-1:0] acc_data_reg;
  logic [OUT_KEEP-1:0]        acc_keep_reg;
  logic [TUSER_WIDTH-1:0]     pkt_tuser_reg;
  logic                       in_packet_reg;
  logic [OUT_TDATA_WIDTH-1:0] out_data_reg;
  logic [OUT_KEEP-1:0]        out_keep_reg;
  logic [TUSER_WIDTH-1:0]     out_tuser_reg;
  logic                       out_last_reg;
  logic                       out_valid_reg;

  logic                       beat_accept;
  logic                       word_complete;
  logic                       out_handshake;
  logic [OUT_TDATA_WIDTH-1:0] merged_data;
  logic [OUT_KEEP-1:0]        merged_keep;

  assign axis_original_tready = ~axis_reset & (~out_valid_reg | axis_resize_tready);
  assign beat_accept          = axis_original_tvalid & axis_original_tready;
  assign out_handshake        = out_valid_reg & axis_resize_tready;
  assign word_complete        = (cnt_reg == CNT_W'(RATIO - 1)) | axis_original_tlast;

  // Slots above cnt are still zero from the last clear, so the merge also zero-fills them.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
      assign merged_data[gi*IN_TDATA_WIDTH +: IN_TDATA_WIDTH] =
        (cnt_reg == CNT_W'(gi)) ? axis_original_tdata
                                : acc_data_reg[gi*IN_TDATA_WIDTH +: IN_TDATA_WIDTH];
      assign merged_keep[gi*IN_KEEP +: IN_KEEP] =
        (cnt_reg == CNT_W'(gi)) ? axis_original_tkeep
                                : acc_keep_reg[gi*IN_KEEP +: IN_KEEP];
    end
  endgenerate

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      cnt_reg       <= '0;
      acc_data_reg  <= '0;
      acc_keep_reg  <= '0;
      pkt_tuser_reg <= '0;
      in_packet_reg <= 1'b0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_tuser_reg <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (beat_accept) begin
      if (!in_packet_reg) pkt_tuser_reg <= axis_original_tuser;
      in_packet_reg <= ~axis_original_tlast;
      if (word_complete) begin
        out_data_reg  <= merged_data;
        out_keep_reg  <= merged_keep;
        // A word started by the packet's first beat has no captured tuser yet.
        out_tuser_reg <= in_packet_reg ? pkt_tuser_reg : axis_original_tuser;
        out_last_reg  <= axis_original_tlast;
        out_valid_reg <= 1'b1;
        cnt_reg       <= '0;
        acc_data_reg  <= '0;
        acc_keep_reg  <= '0;
      end else begin
        cnt_reg      <= cnt_reg + CNT_W'(1);
        acc_data_reg <= merged_data;
        acc_keep_reg <= merged_keep;
        if (out_handshake) out_valid_reg <= 1'b0;
      end
    end else if (out_handshake) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign axis_resize_tdata  = out_data_reg;
  assign axis_resize_tkeep  = out_keep_reg;
  assign axis_resize_tuser  = out_tuser_reg;
  assign axis_resize_tlast  = out_last_reg;
  assign axis_resize_tvalid = out_valid_reg;

`ifdef AXIS_UPSIZER_KEEP_CHECK_EN
  logic [IN_KEEP:0] keep_ext;
  logic [IN_KEEP:0] keep_plus_one;
  logic             keep_bad;
  logic             keep_error_reg;

  // A contiguous low-aligned mask has the form 2^n-1, so mask & (mask+1) is zero.
  assign keep_ext      = {1'b0, axis_original_tkeep};
  assign keep_plus_one = keep_ext + (IN_KEEP+1)'(1);
  assign keep_bad      = (|(keep_ext & keep_plus_one)) |
                         (~axis_original_tlast & ~(&axis_original_tkeep));

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) keep_error_reg <= 1'b0;
    else            keep_error_reg <= beat_accept & keep_bad;
  end

  assign keep_error = keep_error_reg;
`endif

endmodule
